// File: rtl/mem_access_stage_pkg.sv
// Shared encodings, types and small decode helpers for the RV32I memory-access stage.
package mem_access_stage_pkg;

  localparam logic [1:0] MEMRW_LOAD  = 2'b01;
  localparam logic [1:0] MEMRW_STORE = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] BR_COND = 3'b001;
  localparam logic [2:0] BR_JAL  = 3'b010;
  localparam logic [2:0] BR_JALR = 3'b100;

  // Access size lives in funct3[1:0] for both loads and stores.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  wreg;
    logic        reg_write;
    logic [31:0] instr;
  } mem_wb_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) || ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

  // The ALU leaves a compare result in its output: 0 for equal / not-less, 1 for less.
  function automatic logic branch_taken(input logic [2:0] kind, input logic [2:0] f3,
                                        input logic [31:0] alu);
    logic taken;
    taken = 1'b0;
    case (kind)
      BR_COND: begin
        case (f3)
          F3_BEQ, F3_BGE, F3_BGEU: taken = (alu == 32'd0);
          F3_BNE:                  taken = (alu != 32'd0);
          F3_BLT, F3_BLTU:         taken = (alu == 32'd1);
          default:                 taken = 1'b0;
        endcase
      end
      BR_JAL, BR_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Single-outstanding req/ready data-memory port between the MEM stage and data memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage_load_store_align.sv
// Combinational store lane replication / byte enables and load lane extraction with extension.
module mem_access_stage_load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every output gets a value on every path through the block, otherwise
  // synthesis infers a latch to remember the old one.
  always_comb begin
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3[1:0])
      SZ_BYTE: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << offset;
      end
      SZ_HALF: begin
        wdata = {2{store_data[15:0]}};
        be    = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = store_data;
        be    = 4'b1111;
      end
    endcase

    case (funct3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  load_data = {24'd0, lane_b};
      F3_LHU:  load_data = {16'd0, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: one data-memory transaction per instruction,
// branch/jump redirect and the MEM/WB pipeline register.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               keep,
  input  logic               nop,
  input  logic [31:0]        ALU_co_pype,
  input  logic [31:0]        read_data2_pype2,
  input  logic [31:0]        PCBranch_pype2,
  input  logic [31:0]        PCp4_pype2,
  input  logic [4:0]         WReg_pype2,
  input  logic               RegWrite_pype2,
  input  logic [1:0]         MemtoReg_pype2,
  input  logic [1:0]         MemRW_pype2,
  input  logic [2:0]         MemBranch_pype2,
  input  logic [31:0]        Instraction_pype2,
  mem_access_stage_if.master dmem,
  output logic               mem_stall,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               misalign_err,
  output logic [31:0]        WB_data_pype3,
  output logic [4:0]         WReg_pype3,
  output logic               RegWrite_pype3,
  output logic [31:0]        Instraction_pype3
);

  logic [2:0]  funct3;
  logic        is_load, is_store, misaligned, access_valid;
  logic        req_int, stall_int;
  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] rdata_sel, load_data, store_wdata, wb_sel;
  logic [3:0]  store_be;
  mem_wb_t     mw_q, mw_d;

  always_comb begin
    funct3       = Instraction_pype2[14:12];
    is_load      = (MemRW_pype2 == MEMRW_LOAD);
    is_store     = (MemRW_pype2 == MEMRW_STORE);
    misaligned   = (is_load || is_store) && is_misaligned(funct3[1:0], ALU_co_pype[1:0]);
    access_valid = (is_load || is_store) && !misaligned;
    // DONE means this instruction's transaction already happened; never re-issue it.
    req_int      = access_valid && (state_q != ST_DONE);
    stall_int    = req_int && !dmem.dmem_ready;
    rdata_sel    = (state_q == ST_DONE) ? hold_q : dmem.dmem_rdata;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (state_q == ST_DONE) begin
      if (!keep) state_d = ST_IDLE;
    end else if (access_valid) begin
      if (dmem.dmem_ready) begin
        hold_d  = dmem.dmem_rdata;
        state_d = keep ? ST_DONE : ST_IDLE;
      end else begin
        state_d = ST_WAIT;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  mem_access_stage_load_store_align u_align (
    .funct3     (funct3),
    .offset     (ALU_co_pype[1:0]),
    .store_data (read_data2_pype2),
    .rdata      (rdata_sel),
    .wdata      (store_wdata),
    .be         (store_be),
    .load_data  (load_data)
  );

  // nop beats keep; a stalled instruction leaves a bubble behind it.
  always_comb begin
    case (MemtoReg_pype2)
      WB_SEL_ALU:  wb_sel = ALU_co_pype;
      WB_SEL_LOAD: wb_sel = load_data;
      WB_SEL_PC4:  wb_sel = PCp4_pype2;
      default:     wb_sel = '0;
    endcase
    mw_d = mw_q;
    if (nop || (!keep && stall_int)) begin
      mw_d = '0;
    end else if (!keep) begin
      mw_d.wb_data   = wb_sel;
      mw_d.wreg      = WReg_pype2;
      mw_d.reg_write = RegWrite_pype2 && !misaligned;
      mw_d.instr     = Instraction_pype2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      // NOTE: the hold register is a single word, so resetting it is cheap and
      // keeps DONE-state load data deterministic after reset.
      hold_q  <= '0;
      mw_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mw_q    <= mw_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign dmem.dmem_req   = rst && req_int;
  assign dmem.dmem_we    = rst && req_int && is_store;
  assign dmem.dmem_addr  = rst ? {ALU_co_pype[31:2], 2'b00} : '0;
  assign dmem.dmem_wdata = rst ? store_wdata : '0;
  assign dmem.dmem_be    = rst ? store_be : '0;

  assign mem_stall    = rst && stall_int;
  assign pc_redirect  = rst && !stall_int && branch_taken(MemBranch_pype2, funct3, ALU_co_pype);
  assign pc_target    = rst ? PCBranch_pype2 : '0;
  assign misalign_err = rst && misaligned;

  assign WB_data_pype3     = mw_q.wb_data;
  assign WReg_pype3        = mw_q.wreg;
  assign RegWrite_pype3    = mw_q.reg_write;
  assign Instraction_pype3 = mw_q.instr;

endmodule
